// File: rtl/clock_monitor.sv
// Receive-side monitor for a divided clock brought back into the clk domain: edge strobes,
// period/high-time measurement, lock tracking and a sticky fault flag.
module clock_monitor #(
  parameter int unsigned EXP_PERIOD = 8,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             fault
);

  localparam int unsigned GcW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] LoLim   = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HiLim   = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [GcW-1:0]   LockCnt = GcW'(LOCK_COUNT);

  typedef enum logic [1:0] {StUnlocked, StTraining, StLocked, StFault} state_e;

  state_e           state_q, state_d;
  logic             s0_q, s1_q, prev_q;
  logic             rise, fall, good, timeout;
  logic             rise_stb_q, fall_stb_q;
  logic             locked_q, locked_d, fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, period_q, high_time_q;
  logic [GcW-1:0]   good_cnt_q, good_cnt_d, good_inc;

  assign rise     = s1_q & ~prev_q;
  assign fall     = ~s1_q & prev_q;
  // A saturated count is always above HiLim, so it can never be judged good.
  assign good     = (cnt_q >= LoLim) && (cnt_q <= HiLim);
  assign timeout  = ~rise && (cnt_q > HiLim);
  assign good_inc = good_cnt_q + 1'b1;

  // Synchroniser, strobes, cycle counter and measurements.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      prev_q      <= 1'b0;
      rise_stb_q  <= 1'b0;
      fall_stb_q  <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      high_time_q <= '0;
    end else begin
      s0_q       <= mon_clk;
      s1_q       <= s0_q;
      prev_q     <= s1_q;
      rise_stb_q <= rise;
      fall_stb_q <= fall;
      if (rise) begin
        cnt_q <= CNT_W'(1);
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (rise && (state_q != StUnlocked)) period_q    <= cnt_q;
      if (fall && (state_q != StUnlocked)) high_time_q <= cnt_q;
    end
  end

  // FSM state register; locked/fault are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StUnlocked;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      StUnlocked: begin
        if (rise) begin
          state_d    = StTraining;
          good_cnt_d = '0;
        end
      end
      StTraining, StFault: begin
        if (rise) begin
          if (good) begin
            good_cnt_d = good_inc;
            if (good_inc == LockCnt) state_d = StLocked;
          end else begin
            good_cnt_d = '0;
          end
        end else if (timeout && (state_q == StTraining)) begin
          state_d = StUnlocked;
        end
      end
      StLocked: begin
        if ((rise && !good) || timeout) begin
          state_d    = StFault;
          good_cnt_d = '0;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  always_comb begin
    locked_d = (state_d == StLocked);
    fault_d  = fault_q | ((state_q == StLocked) && (state_d == StFault));
  end

  assign rise_stb  = rise_stb_q;
  assign fall_stb  = fall_stb_q;
  assign period    = period_q;
  assign high_time = high_time_q;
  assign locked    = locked_q;
  assign fault     = fault_q;

endmodule
